// File: rtl/ddr_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ddr_cmd_pkg
// Shared types and constants for the DDR3 command issue stage.
//   ddr_cmd_e      abstract command codes carried on req_cmd
//   RCW_*          {ras_n, cas_n, we_n} pin patterns for each command
//   bank_state_t   per-bank tracking state {open, row, rcd, ras, rp}
//   max4()         helper used to size the timing counters
// ---------------------------------------------------------------------------
package ddr_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } ddr_cmd_e;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] RCW_NOP = 3'b111;
    localparam logic [2:0] RCW_ACT = 3'b011;
    localparam logic [2:0] RCW_RD  = 3'b101;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_REF = 3'b001;

    // The struct lives in a package, so its fields are sized for the widest
    // supported configuration; bits above ROW_WIDTH / the counter width
    // simply stay zero.
    localparam int ROW_W_MAX = 16;
    localparam int CNT_W_MAX = 8;

    typedef struct packed {
        logic                 open;
        logic [ROW_W_MAX-1:0] row;
        logic [CNT_W_MAX-1:0] rcd;
        logic [CNT_W_MAX-1:0] ras;
        logic [CNT_W_MAX-1:0] rp;
    } bank_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [2:0] cmd_pins(input logic [2:0] cmd);
        case (cmd)
            CMD_ACT: return RCW_ACT;
            CMD_RD:  return RCW_RD;
            CMD_WR:  return RCW_WR;
            CMD_PRE: return RCW_PRE;
            CMD_REF: return RCW_REF;
            default: return RCW_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// ---------------------------------------------------------------------------
// ddr_bank_tracker
// Open/closed state and timing counters for a single DDR3 bank.
// Ports:
//   clk_i      clock
//   srst_i     synchronous active-high reset: bank CLOSED, counters 0
//   act_i      legal ACT issued to this bank this cycle
//   pre_i      legal PRE (single or all-bank) issued to this bank this cycle
//   row_i      row address captured on ACT
//   act_ok_o   rp has expired: ACT (and REF, rank-wide) may go
//   rw_ok_o    rcd has expired: RD/WR may go
//   pre_ok_o   ras has expired: PRE may go
//   is_open_o  bank currently holds an open row
// ---------------------------------------------------------------------------
module ddr_bank_tracker
    import ddr_cmd_pkg::*;
#(
    parameter int ROW_WIDTH = 14,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_RAS     = 15
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 act_i,
    input  logic                 pre_i,
    input  logic [ROW_WIDTH-1:0] row_i,
    output logic                 act_ok_o,
    output logic                 rw_ok_o,
    output logic                 pre_ok_o,
    output logic                 is_open_o
);

    bank_state_t state_q;
    bank_state_t state_d;

    always_comb begin
        state_d = state_q;

        // Free-running saturating down-counters.
        if (state_q.rcd != '0) state_d.rcd = state_q.rcd - CNT_W_MAX'(1);
        if (state_q.ras != '0) state_d.ras = state_q.ras - CNT_W_MAX'(1);
        if (state_q.rp  != '0) state_d.rp  = state_q.rp  - CNT_W_MAX'(1);

        // Loads use T-1 because the load edge itself is the first cycle
        // after the command appears on the pins.
        if (act_i) begin
            state_d.open = 1'b1;
            state_d.row  = ROW_W_MAX'(row_i);
            state_d.rcd  = CNT_W_MAX'(T_RCD - 1);
            state_d.ras  = CNT_W_MAX'(T_RAS - 1);
        end
        if (pre_i) begin
            state_d.open = 1'b0;
            state_d.rp   = CNT_W_MAX'(T_RP - 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign act_ok_o  = (state_q.rp  == '0);
    assign rw_ok_o   = (state_q.rcd == '0);
    assign pre_ok_o  = (state_q.ras == '0);
    assign is_open_o = state_q.open;

    // The open row is kept for debug visibility; nothing downstream reads it.
    logic unused_row;
    assign unused_row = ^state_q.row;

endmodule

// File: rtl/ddr_cmd_timing_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_cmd_timing_ctrl
// DDR3 command issue stage: takes abstract commands over valid/ready, holds
// them off until per-bank tRCD/tRP/tRAS and per-rank tRFC are satisfied, and
// drives registered DDR pins one cycle after acceptance. Protocol-illegal
// commands are accepted, dropped (pins NOP) and flagged on proto_err.
// Ports:
//   ck_t, reset                 clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (req_ready combinational)
//   req_cmd                     ddr_cmd_e code
//   req_rank, req_ba, req_addr  target rank, bank, row/column (a[10]=PRE-all)
//   cs_n                        per-rank chip selects, active low
//   ras_n, cas_n, we_n          command strobes
//   ba, a                       bank and address bus (hold on NOP)
//   cke                         clock enable, 1 from first cycle after reset
//   proto_err                   one-cycle pulse for an illegal accepted command
// ---------------------------------------------------------------------------
module ddr_cmd_timing_ctrl
    import ddr_cmd_pkg::*;
#(
    parameter int NUM_RANKS = 2,
    parameter int BA_WIDTH  = 3,
    parameter int ROW_WIDTH = 14,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_RAS     = 15,
    parameter int T_RFC     = 44,
    localparam int RANK_W   = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_cmd,
    input  logic [RANK_W-1:0]    req_rank,
    input  logic [BA_WIDTH-1:0]  req_ba,
    input  logic [ROW_WIDTH-1:0] req_addr,
    output logic [NUM_RANKS-1:0] cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_WIDTH-1:0]  ba,
    output logic [ROW_WIDTH-1:0] a,
    output logic                 cke,
    output logic                 proto_err
);

    localparam int BANKS = 2 ** BA_WIDTH;
    localparam int CNT_W = $clog2(max4(T_RCD, T_RP, T_RAS, T_RFC) + 1);

    // Per-bank status, one vector per rank.
    logic [BANKS-1:0] act_ok  [NUM_RANKS];
    logic [BANKS-1:0] rw_ok   [NUM_RANKS];
    logic [BANKS-1:0] pre_ok  [NUM_RANKS];
    logic [BANKS-1:0] is_open [NUM_RANKS];

    logic [CNT_W-1:0] rfc_q [NUM_RANKS];

    logic pre_all;
    logic is_cmd;
    logic cmd_ok;
    logic legal;
    logic accept;
    logic issue;
    logic err;
    logic issue_act;
    logic issue_pre;
    logic issue_ref;

    assign pre_all = req_addr[10];

    // -----------------------------------------------------------------------
    // Readiness (timing) and legality (bank state) of the current request
    // -----------------------------------------------------------------------
    always_comb begin
        logic rank_idle;
        logic sel_open;
        rank_idle = (rfc_q[req_rank] == '0);
        sel_open  = is_open[req_rank][req_ba];
        cmd_ok    = 1'b1;
        legal     = 1'b0;
        is_cmd    = 1'b1;
        case (req_cmd)
            CMD_ACT: begin
                cmd_ok = rank_idle && act_ok[req_rank][req_ba];
                legal  = !sel_open;
            end
            CMD_RD, CMD_WR: begin
                cmd_ok = rank_idle && rw_ok[req_rank][req_ba];
                legal  = sel_open;
            end
            CMD_PRE: begin
                cmd_ok = rank_idle && (pre_all ? (&pre_ok[req_rank])
                                               : pre_ok[req_rank][req_ba]);
                legal  = 1'b1;
            end
            CMD_REF: begin
                // act_ok is "rp expired", which is exactly the REF condition.
                cmd_ok = rank_idle && (&act_ok[req_rank]);
                legal  = ~|is_open[req_rank];
            end
            default: begin
                // NOP and unused codes are always taken and never issue.
                is_cmd = 1'b0;
            end
        endcase
    end

    assign req_ready = !reset && cmd_ok;
    assign accept    = req_valid && req_ready;
    assign issue     = accept && is_cmd && legal;
    assign err       = accept && is_cmd && !legal;
    assign issue_act = issue && (req_cmd == CMD_ACT);
    assign issue_pre = issue && (req_cmd == CMD_PRE);
    assign issue_ref = issue && (req_cmd == CMD_REF);

    // -----------------------------------------------------------------------
    // Bank trackers and per-rank refresh counters
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
        logic rank_hit;
        assign rank_hit = (req_rank == RANK_W'(gi));

        for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
            logic bank_hit;
            assign bank_hit = (req_ba == BA_WIDTH'(gb));

            ddr_bank_tracker #(
                .ROW_WIDTH (ROW_WIDTH),
                .T_RCD     (T_RCD),
                .T_RP      (T_RP),
                .T_RAS     (T_RAS)
            ) u_bank (
                .clk_i     (ck_t),
                .srst_i    (reset),
                .act_i     (issue_act && rank_hit && bank_hit),
                .pre_i     (issue_pre && rank_hit && (pre_all || bank_hit)),
                .row_i     (req_addr),
                .act_ok_o  (act_ok[gi][gb]),
                .rw_ok_o   (rw_ok[gi][gb]),
                .pre_ok_o  (pre_ok[gi][gb]),
                .is_open_o (is_open[gi][gb])
            );
        end

        always_ff @(posedge ck_t) begin
            if (reset) begin
                rfc_q[gi] <= '0;
            end else if (issue_ref && rank_hit) begin
                rfc_q[gi] <= CNT_W'(T_RFC - 1);
            end else if (rfc_q[gi] != '0) begin
                rfc_q[gi] <= rfc_q[gi] - CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered pin interface
    // -----------------------------------------------------------------------
    logic [NUM_RANKS-1:0] cs_n_q,  cs_n_d;
    logic [2:0]           rcw_q,   rcw_d;
    logic [BA_WIDTH-1:0]  ba_q,    ba_d;
    logic [ROW_WIDTH-1:0] a_q,     a_d;
    logic                 cke_q;
    logic                 err_q;

    always_comb begin
        cs_n_d = '1;
        rcw_d  = RCW_NOP;
        ba_d   = ba_q;
        a_d    = a_q;
        if (issue) begin
            cs_n_d[req_rank] = 1'b0;
            rcw_d            = cmd_pins(req_cmd);
            ba_d             = req_ba;
            a_d              = req_addr;
        end
    end

    always_ff @(posedge ck_t) begin
        if (reset) begin
            cs_n_q <= '1;
            rcw_q  <= RCW_NOP;
            ba_q   <= '0;
            a_q    <= '0;
            cke_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            rcw_q  <= rcw_d;
            ba_q   <= ba_d;
            a_q    <= a_d;
            cke_q  <= 1'b1;
            err_q  <= err;
        end
    end

    assign cs_n      = cs_n_q;
    assign ras_n     = rcw_q[2];
    assign cas_n     = rcw_q[1];
    assign we_n      = rcw_q[0];
    assign ba        = ba_q;
    assign a         = a_q;
    assign cke       = cke_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_ddr_cmd_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_timing_ctrl
// Directed scenarios with literal expectations, then randomized traffic.
// A time-stamp model (last ACT/PRE/REF pin cycle per bank/rank plus an open
// flag) predicts req_ready and the pins; it is checked every cycle.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_timing_ctrl;

    localparam int NR    = 2;
    localparam int NB    = 8;
    localparam int T_RCD = 5;
    localparam int T_RP  = 5;
    localparam int T_RAS = 15;
    localparam int T_RFC = 44;
    localparam int NEVER = -100000;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    logic        ck_t      = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_cmd   = 3'd0;
    logic [0:0]  req_rank  = 1'b0;
    logic [2:0]  req_ba    = 3'd0;
    logic [13:0] req_addr  = 14'd0;
    logic        req_ready;
    logic [1:0]  cs_n;
    logic        ras_n, cas_n, we_n, cke, proto_err;
    logic [2:0]  ba;
    logic [13:0] a;

    ddr_cmd_timing_ctrl #(
        .NUM_RANKS (NR), .BA_WIDTH (3), .ROW_WIDTH (14),
        .T_RCD (T_RCD), .T_RP (T_RP), .T_RAS (T_RAS), .T_RFC (T_RFC)
    ) dut (
        .ck_t (ck_t), .reset (reset), .req_valid (req_valid), .req_ready (req_ready),
        .req_cmd (req_cmd), .req_rank (req_rank), .req_ba (req_ba), .req_addr (req_addr),
        .cs_n (cs_n), .ras_n (ras_n), .cas_n (cas_n), .we_n (we_n),
        .ba (ba), .a (a), .cke (cke), .proto_err (proto_err)
    );

    always #5 ck_t = ~ck_t;

    int cyc = 0;
    always @(posedge ck_t) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_open [NR][NB];
    int m_act  [NR][NB];
    int m_pre  [NR][NB];
    int m_ref  [NR];

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_ref[r] = NEVER;
            for (int b = 0; b < NB; b++) begin
                m_open[r][b] = 1'b0;
                m_act[r][b]  = NEVER;
                m_pre[r][b]  = NEVER;
            end
        end
    endtask

    // A command sampled now would reach the pins at cycle cyc+1; it may go
    // once that pin cycle is far enough from the relevant earlier pin cycle.
    function automatic bit model_ready();
        int r, b, pin;
        if (reset) return 1'b0;
        if (req_cmd == C_NOP || req_cmd > C_REF) return 1'b1;
        r   = int'(req_rank);
        b   = int'(req_ba);
        pin = cyc + 1;
        if (pin - m_ref[r] < T_RFC) return 1'b0;
        case (req_cmd)
            C_ACT: return (pin - m_pre[r][b] >= T_RP);
            C_RD, C_WR: return (pin - m_act[r][b] >= T_RCD);
            C_PRE: begin
                if (req_addr[10]) begin
                    for (int bb = 0; bb < NB; bb++)
                        if (pin - m_act[r][bb] < T_RAS) return 1'b0;
                    return 1'b1;
                end
                return (pin - m_act[r][b] >= T_RAS);
            end
            default: begin
                for (int bb = 0; bb < NB; bb++)
                    if (pin - m_pre[r][bb] < T_RP) return 1'b0;
                return 1'b1;
            end
        endcase
    endfunction

    logic [1:0]  e_cs_n = 2'b11;
    logic [2:0]  e_rcw  = 3'b111;
    logic [2:0]  e_ba   = 3'd0;
    logic [13:0] e_a    = 14'd0;
    logic        e_cke  = 1'b0;
    logic        e_err  = 1'b0;

    initial model_clear();

    always @(negedge ck_t) begin : compare
        bit rdy, legal, any_open;
        int r, b, pin;
        chk("cs_n", 32'(cs_n), 32'(e_cs_n));
        chk("rcw", 32'({ras_n, cas_n, we_n}), 32'(e_rcw));
        chk("ba", 32'(ba), 32'(e_ba));
        chk("a", 32'(a), 32'(e_a));
        chk("cke", 32'(cke), 32'(e_cke));
        chk("proto_err", 32'(proto_err), 32'(e_err));
        rdy = model_ready();
        chk("req_ready", 32'(req_ready), 32'(rdy));

        e_cs_n = 2'b11;
        e_rcw  = 3'b111;
        e_err  = 1'b0;
        if (reset) begin
            model_clear();
            e_cke = 1'b0;
            e_a   = '0;
            e_ba  = '0;
        end else begin
            e_cke = 1'b1;
            if (req_valid && rdy && req_cmd >= C_ACT && req_cmd <= C_REF) begin
                r   = int'(req_rank);
                b   = int'(req_ba);
                pin = cyc + 1;
                any_open = 1'b0;
                for (int bb = 0; bb < NB; bb++) any_open |= m_open[r][bb];
                case (req_cmd)
                    C_ACT:      legal = !m_open[r][b];
                    C_RD, C_WR: legal = m_open[r][b];
                    C_PRE:      legal = 1'b1;
                    default:    legal = !any_open;
                endcase
                if (!legal) begin
                    e_err = 1'b1;
                end else begin
                    e_cs_n[req_rank] = 1'b0;
                    e_a  = req_addr;
                    e_ba = req_ba;
                    case (req_cmd)
                        C_ACT: begin
                            e_rcw = 3'b011;
                            m_open[r][b] = 1'b1;
                            m_act[r][b]  = pin;
                        end
                        C_RD: e_rcw = 3'b101;
                        C_WR: e_rcw = 3'b100;
                        C_PRE: begin
                            e_rcw = 3'b010;
                            for (int bb = 0; bb < NB; bb++) begin
                                if (req_addr[10] || bb == b) begin
                                    m_open[r][bb] = 1'b0;
                                    m_pre[r][bb]  = pin;
                                end
                            end
                        end
                        default: begin
                            e_rcw = 3'b001;
                            m_ref[r] = pin;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drives one request, holds it until accepted; returns at the pin cycle.
    task automatic do_cmd(input logic [2:0] c, input logic [0:0] r, input logic [2:0] b,
                          input logic [13:0] ad, output int acc, output int waited);
        req_valid = 1'b1;
        req_cmd   = c;
        req_rank  = r;
        req_ba    = b;
        req_addr  = ad;
        waited    = 0;
        acc       = -1;
        forever begin
            @(negedge ck_t);
            if (req_ready) begin
                acc = cyc;
                break;
            end
            waited++;
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: cmd %0d not accepted within 200 cycles", c);
                break;
            end
        end
        @(posedge ck_t);
        #1;
        req_valid = 1'b0;
        req_cmd   = C_NOP;
    endtask

    task automatic pick();
        int k;
        k = $urandom_range(0, 99);
        req_valid = (k < 85);
        req_rank  = 1'($urandom_range(0, 1));
        req_ba    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
        req_addr  = 14'($urandom);
        k = $urandom_range(0, 99);
        if (k < 30)      req_cmd = C_ACT;
        else if (k < 45) req_cmd = C_RD;
        else if (k < 58) req_cmd = C_WR;
        else if (k < 85) req_cmd = C_PRE;
        else if (k < 92) req_cmd = C_REF;
        else             req_cmd = C_NOP;
        if (req_cmd == C_PRE) req_addr[10] = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x_act, x_rd, x_pre, x_act2, x_ref, x_act0, x_act1, x_b5, x_pall, x_act5, acc, w;
        bit acc_prev;

        // Reset with a request pending
        reset = 1'b1;
        req_valid = 1'b1; req_cmd = C_ACT; req_rank = 1'b0; req_ba = 3'd2; req_addr = 14'h155;
        repeat (3) @(posedge ck_t);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'h3);
        chk("rst_cke", 32'(cke), 32'd0);
        chk("rst_rcw", 32'({ras_n, cas_n, we_n}), 32'h7);
        reset = 1'b0; req_valid = 1'b0; req_cmd = C_NOP;
        @(posedge ck_t);
        #1;
        chk("cke_rise", 32'(cke), 32'd1);

        // ACT r0 b2 row 0x155, then RD, PRE and ACT to the same bank
        do_cmd(C_ACT, 1'b0, 3'd2, 14'h155, x_act, w);
        chk("act_cs_n", 32'(cs_n), 32'h2);
        chk("act_a", 32'(a), 32'h155);
        chk("act_ba", 32'(ba), 32'd2);
        chk("act_rcw", 32'({ras_n, cas_n, we_n}), 32'h3);
        do_cmd(C_RD, 1'b0, 3'd2, 14'h010, x_rd, w);
        chk("trcd_gap", 32'(x_rd - x_act), 32'd5);
        chk("rd_rcw", 32'({ras_n, cas_n, we_n}), 32'h5);
        do_cmd(C_PRE, 1'b0, 3'd2, 14'h000, x_pre, w);
        chk("tras_gap", 32'(x_pre - x_act), 32'd15);
        do_cmd(C_ACT, 1'b0, 3'd2, 14'h0aa, x_act2, w);
        chk("trp_gap", 32'(x_act2 - x_pre), 32'd5);

        // RD to closed r1 b0: dropped with proto_err, bank stays closed
        do_cmd(C_RD, 1'b1, 3'd0, 14'h020, acc, w);
        chk("err_wait", 32'(w), 32'd0);
        chk("err_pulse", 32'(proto_err), 32'd1);
        chk("err_cs_n", 32'(cs_n), 32'h3);
        @(posedge ck_t);
        #1;
        chk("err_clear", 32'(proto_err), 32'd0);
        do_cmd(C_RD, 1'b1, 3'd0, 14'h020, acc, w);
        chk("still_closed", 32'(proto_err), 32'd1);

        // REF r1 stalls rank 1 only
        do_cmd(C_REF, 1'b1, 3'd0, 14'h000, x_ref, w);
        chk("ref_rcw", 32'({ras_n, cas_n, we_n}), 32'h1);
        do_cmd(C_ACT, 1'b0, 3'd0, 14'h033, x_act0, w);
        chk("other_rank_free", 32'(x_act0 - x_ref), 32'd1);
        do_cmd(C_ACT, 1'b1, 3'd1, 14'h044, x_act1, w);
        chk("trfc_gap", 32'(x_act1 - x_ref), 32'd44);

        // PRE-all on rank 0 with b1 and b5 open
        do_cmd(C_ACT, 1'b0, 3'd1, 14'h101, acc, w);
        do_cmd(C_ACT, 1'b0, 3'd5, 14'h105, x_b5, w);
        do_cmd(C_PRE, 1'b0, 3'd0, 14'h400, x_pall, w);
        chk("preall_tras", 32'(x_pall - x_b5), 32'd15);
        do_cmd(C_ACT, 1'b0, 3'd5, 14'h205, x_act5, w);
        chk("preall_trp", 32'(x_act5 - x_pall), 32'd5);
        chk("b5_reopen_ok", 32'(proto_err), 32'd0);
        do_cmd(C_RD, 1'b0, 3'd1, 14'h000, acc, w);
        chk("b1_closed", 32'(proto_err), 32'd1);

        // Reset during a tRFC countdown leaves no residual stall
        do_cmd(C_PRE, 1'b1, 3'd0, 14'h400, acc, w);
        do_cmd(C_REF, 1'b1, 3'd0, 14'h000, acc, w);
        repeat (5) @(posedge ck_t);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge ck_t);
        #1;
        reset = 1'b0;
        do_cmd(C_ACT, 1'b1, 3'd3, 14'h333, acc, w);
        chk("post_reset_nostall", 32'(w), 32'd0);
        chk("post_reset_cs_n", 32'(cs_n), 32'h1);

        // Randomized traffic, holding requests while stalled
        for (int i = 0; i < 4000; i++) begin
            @(negedge ck_t);
            acc_prev = req_valid && req_ready;
            @(posedge ck_t);
            #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                req_valid = 1'b0;
            end
            if (!reset && (!req_valid || acc_prev)) pick();
        end
        req_valid = 1'b0;
        req_cmd   = C_NOP;
        repeat (4) @(posedge ck_t);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
